rv32_multicycle_core: RTL and testbench

//  Multicycle RV32I-subset processor core; top of the CPU datapath. Fetches from an

---
 rtl/rv32_multicycle_core.sv | 202 ++++++++++++++++++++
 tb/tb_rv32_multicycle_core.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rv32_multicycle_core.sv
// rv32_multicycle_core: multicycle RV32I-subset core stepping IF -> ID -> EX -> MEM -> WB.
// Instruction ROM and data RAM are external and synchronous.
// Optional feature macro BRANCH_EXT_EN: also decode BNE, BLT and BGE (signed).
module rv32_multicycle_core #(
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] dReadData,
    output logic [31:0] PC,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] WriteBackData
);
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb} state_e;
    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSlt, AluSll, AluSrl, AluSra
    } alu_op_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, rs1_q, rs2_q, imm_q, alu_q;
    logic [21:0] ir_q;  // {funct7, funct3, rd, opcode}; the rest is consumed in ID
    logic        taken_q;
    logic [31:0] rf_q [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write, is_load, is_store, is_branch, use_imm;
    alu_op_e     alu_op, base_op;
    logic [31:0] imm_id, op_a, op_b, alu_res;
    logic        lt, zero, cond;

    assign {funct7, funct3, rd, opcode} = ir_q;

    // Control decode from the latched instruction; anything unrecognised decodes as a NOP
    always_comb begin
        reg_write = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        use_imm   = 1'b0;
        alu_op    = AluAdd;
        case (funct3)
            3'b000:  base_op = (opcode == OpReg && funct7[5]) ? AluSub : AluAdd;
            3'b001:  base_op = AluSll;
            3'b010:  base_op = AluSlt;
            3'b100:  base_op = AluXor;
            3'b101:  base_op = funct7[5] ? AluSra : AluSrl;
            3'b110:  base_op = AluOr;
            default: base_op = AluAnd;  // 3'b011 (unsigned compare) is rejected below
        endcase
        case (opcode)
            OpReg: begin
                alu_op    = base_op;
                reg_write = (funct3 != 3'b011) &&
                            ((funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OpImm: begin
                alu_op  = base_op;
                use_imm = 1'b1;
                case (funct3)
                    3'b001:  reg_write = (funct7 == 7'b0000000);
                    3'b101:  reg_write = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    3'b011:  reg_write = 1'b0;
                    default: reg_write = 1'b1;
                endcase
            end
            OpLoad: begin
                use_imm   = 1'b1;
                is_load   = (funct3 == 3'b010);
                reg_write = (funct3 == 3'b010);
            end
            OpStore: begin
                use_imm  = 1'b1;
                is_store = (funct3 == 3'b010);
            end
            OpBranch: begin
                alu_op = AluSub;
`ifdef BRANCH_EXT_EN
                is_branch = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                            (funct3 == 3'b100) || (funct3 == 3'b101);
`else
                is_branch = (funct3 == 3'b000);
`endif
            end
            default: ;
        endcase
    end

    // Immediate generation in ID straight from the ROM output
    always_comb begin
        case (instr[6:0])
            OpStore:  imm_id = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OpBranch: imm_id = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            default:  imm_id = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    assign op_a = rs1_q;
    assign op_b = use_imm ? imm_q : rs2_q;
    assign lt   = $signed(op_a) < $signed(op_b);

    // ALU evaluated in EX
    always_comb begin
        case (alu_op)
            AluSub:  alu_res = op_a - op_b;
            AluAnd:  alu_res = op_a & op_b;
            AluOr:   alu_res = op_a | op_b;
            AluXor:  alu_res = op_a ^ op_b;
            AluSlt:  alu_res = {31'b0, lt};
            AluSll:  alu_res = op_a << op_b[4:0];
            AluSrl:  alu_res = op_a >> op_b[4:0];
            AluSra:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            default: alu_res = op_a + op_b;
        endcase
    end

    assign zero = (alu_res == 32'b0);

    // Branch condition on the rs1 - rs2 comparison
    always_comb begin
        case (funct3)
            3'b000:  cond = zero;
`ifdef BRANCH_EXT_EN
            3'b001:  cond = !zero;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
`endif
            default: cond = 1'b0;
        endcase
    end

    // Fixed five-step sequence, no stalls
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIf:    state_d = StId;
            StId:    state_d = StEx;
            StEx:    state_d = StMem;
            StMem:   state_d = StWb;
            default: state_d = StIf;
        endcase
    end

    // State, PC and the per-phase datapath latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIf;
            pc_q    <= INITIAL_PC;
            ir_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StId) begin
                ir_q  <= {instr[31:25], instr[14:12], instr[11:7], instr[6:0]};
                rs1_q <= rf_q[instr[19:15]];
                rs2_q <= rf_q[instr[24:20]];
                imm_q <= imm_id;
            end
            if (state_q == StEx) begin
                alu_q   <= alu_res;
                taken_q <= is_branch && cond;
            end
            if (state_q == StWb) begin
                pc_q <= taken_q ? pc_q + imm_q : pc_q + 32'd4;
            end
        end
    end

    // Register file write port; x0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (state_q == StWb && reg_write && rd != 5'd0) begin
            rf_q[rd] <= WriteBackData;
        end
    end

    assign PC            = pc_q;
    assign dAddress      = alu_q;
    assign dWriteData    = rs2_q;
    assign MemRead       = (state_q == StMem) && is_load;
    assign MemWrite      = (state_q == StMem) && is_store;
    assign WriteBackData = is_load ? dReadData : alu_q;

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Bench for rv32_multicycle_core: feeds an instruction sequence through a registered ROM model,
// backs data accesses with a small registered RAM, and scores each instruction's effects.
module tb_rv32_multicycle_core;
    localparam logic [31:0] InitPc = 32'h00400000;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] dReadData;
    logic [31:0] PC;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] WriteBackData;

    rv32_multicycle_core #(
        .INITIAL_PC(InitPc)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .dReadData    (dReadData),
        .PC           (PC),
        .dAddress     (dAddress),
        .dWriteData   (dWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .WriteBackData(WriteBackData)
    );

    typedef struct {
        string       tag;
        logic [31:0] word;
        bit          wb_chk;
        logic [31:0] wb;
        bit          mr;
        bit          mw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delta;
    } exp_t;

    exp_t        tab[$];
    exp_t        exp_q[$];
    exp_t        cur;
    int          n_cmp;
    int          n_err;
    int          phase = -1;
    logic [31:0] exp_pc = InitPc;
    logic [31:0] prog_word;
    logic [31:0] ram [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM and RAM models
    always @(posedge clk) begin
        instr     <= prog_word;
        if (MemWrite) ram[dAddress[5:2]] <= dWriteData;
        dReadData <= ram[dAddress[5:2]];
    end

    // Phase of the instruction in flight: 0=IF .. 4=WB
    always @(posedge clk) begin
        if (rst) phase <= 0;
        else if (phase >= 0) phase <= (phase == 4) ? 0 : phase + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] word, input bit wb_chk,
                                input logic [31:0] wb, input bit mr, input bit mw,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int delta);
        exp_t e;
        e.tag = tag; e.word = word; e.wb_chk = wb_chk; e.wb = wb; e.mr = mr; e.mw = mw;
        e.addr = addr; e.wdata = wdata; e.delta = delta;
        return e;
    endfunction

    // Monitor: compare DUT outputs at mid-cycle against the head of the scoreboard
    always @(negedge clk) begin
        if (phase == 0) begin
            check_eq("pc at IF", PC, exp_pc);
            check_eq("mem strobes at IF", {30'b0, MemRead, MemWrite}, 32'd0);
        end else if (phase == 2 && exp_q.size() > 0) begin
            check_eq({exp_q[0].tag, " strobes at EX"}, {30'b0, MemRead, MemWrite}, 32'd0);
        end else if (phase == 3 && exp_q.size() > 0) begin
            cur = exp_q[0];
            check_eq({cur.tag, " MemRead"}, {31'b0, MemRead}, {31'b0, cur.mr});
            check_eq({cur.tag, " MemWrite"}, {31'b0, MemWrite}, {31'b0, cur.mw});
            if (cur.mr || cur.mw) check_eq({cur.tag, " dAddress"}, dAddress, cur.addr);
            if (cur.mw) check_eq({cur.tag, " dWriteData"}, dWriteData, cur.wdata);
        end else if (phase == 4 && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_eq({cur.tag, " pc at WB"}, PC, exp_pc);
            if (cur.wb_chk) check_eq({cur.tag, " WriteBackData"}, WriteBackData, cur.wb);
            exp_pc = exp_pc + cur.delta;
        end
    end

    // Driver: one table entry per five-cycle instruction
    initial begin
        n_cmp     = 0;
        n_err     = 0;
        prog_word = 32'h00000013;
        for (int i = 0; i < 16; i++) ram[i] = '0;

        tab.push_back(mk("nop",        32'h00000013, 1, 32'h0,        0, 0, 0, 0, 4));
        tab.push_back(mk("addi x1",    32'h00500093, 1, 32'd5,        0, 0, 0, 0, 4));
        tab.push_back(mk("addi x2",    32'hFFD00113, 1, 32'hFFFFFFFD, 0, 0, 0, 0, 4));
        tab.push_back(mk("add x3",     32'h002081B3, 1, 32'd2,        0, 0, 0, 0, 4));
        tab.push_back(mk("beq taken",  32'hFE108CE3, 0, 32'h0,        0, 0, 0, 0, -8));
        tab.push_back(mk("beq not",    32'h00208463, 0, 32'h0,        0, 0, 0, 0, 4));
        tab.push_back(mk("sw x1",      32'h00102423, 0, 32'h0,        0, 1, 8, 5, 4));
        tab.push_back(mk("lw x4",      32'h00802203, 1, 32'd5,        1, 0, 8, 0, 4));
        tab.push_back(mk("slti x5",    32'h00012293, 1, 32'd1,        0, 0, 0, 0, 4));
        tab.push_back(mk("srai x6",    32'h40115313, 1, 32'hFFFFFFFE, 0, 0, 0, 0, 4));
        tab.push_back(mk("srli x7",    32'h01C15393, 1, 32'h0000000F, 0, 0, 0, 0, 4));
        tab.push_back(mk("addi x0",    32'h00700013, 1, 32'd7,        0, 0, 0, 0, 4));
        tab.push_back(mk("add x8 x0",  32'h00000433, 1, 32'd0,        0, 0, 0, 0, 4));
        tab.push_back(mk("add x9",     32'h004184B3, 1, 32'd7,        0, 0, 0, 0, 4));
`ifdef BRANCH_EXT_EN
        tab.push_back(mk("blt",        32'h00114663, 0, 32'h0,        0, 0, 0, 0, 12));
`else
        tab.push_back(mk("blt as nop", 32'h00114663, 0, 32'h0,        0, 0, 0, 0, 4));
`endif
        tab.push_back(mk("sub x10",    32'h40208533, 1, 32'd8,        0, 0, 0, 0, 4));
        tab.push_back(mk("sll x11",    32'h001095B3, 1, 32'h000000A0, 0, 0, 0, 0, 4));
        tab.push_back(mk("bad opcode", 32'h0000007F, 0, 32'h0,        0, 0, 0, 0, 4));
        tab.push_back(mk("slt x12",    32'h00112633, 1, 32'd1,        0, 0, 0, 0, 4));
        tab.push_back(mk("mul as nop", 32'h021086B3, 0, 32'h0,        0, 0, 0, 0, 4));
        tab.push_back(mk("x13 unset",  32'h00068733, 1, 32'd0,        0, 0, 0, 0, 4));

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        foreach (tab[k]) begin
            prog_word = tab[k].word;
            exp_q.push_back(tab[k]);
            repeat (5) @(negedge clk);
        end
        prog_word = 32'h00000013;
        @(negedge clk);
        #1;
        check_eq("scoreboard drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
